clock_ctrl: RTL and testbench

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_pkg.sv | 20 ++
 rtl/bcd_mod_counter.sv | 39 +++
 rtl/clock_ctrl.sv | 109 ++++++++++
 tb/tb_clock_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared state enum, BCD digit type and time limits for clock_ctrl
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [7:0] MIN_SEC_MAX = 8'h59;
  localparam logic [7:0] HR24_MAX    = 8'h23;
  localparam logic [7:0] HR12_MAX    = 8'h12;

  function automatic logic [7:0] hr_limit(input logic twelve_hr);
    return twelve_hr ? HR12_MAX : HR24_MAX;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD counter wrapping max_val -> MIN_VAL, clearing to RST_VAL
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  input  logic [7:0] max_val,
  output logic [7:0] value,
  output logic       carry
);

  bcd_digit_t tens;
  bcd_digit_t units;

  assign {tens, units} = value;
  assign carry = inc && (value == max_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= RST_VAL;
    end else if (clr) begin
      value <= RST_VAL;
    end else if (inc) begin
      if (value == max_val) begin
        value <= MIN_VAL;
      end else if (units == 4'd9) begin
        value <= {tens + 4'd1, 4'd0};
      end else begin
        value <= {tens, units + 4'd1};
      end
    end
  end

endmodule

// File: rtl/clock_ctrl.sv
// rtl/clock_ctrl.sv - HH:MM:SS clock with RUN/SET_HR/SET_MIN modes and idle auto-return
// CLOCK_CTRL_12H_EN selects 12-hour format with pm indicator; default is 24-hour.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int AUTO_RUN_TIMEOUT = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [7:0] hr_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       pm
);

  localparam int IW = $clog2(AUTO_RUN_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(AUTO_RUN_TIMEOUT - 1);

`ifdef CLOCK_CTRL_12H_EN
  localparam logic       TWELVE_HR = 1'b1;
  localparam logic [7:0] HR_MIN    = 8'h01;
  localparam logic [7:0] HR_RST    = 8'h12;
`else
  localparam logic       TWELVE_HR = 1'b0;
  localparam logic [7:0] HR_MIN    = 8'h00;
  localparam logic [7:0] HR_RST    = 8'h00;
`endif

  state_t          state, next_state;
  logic [IW-1:0]   idle, next_idle;
  logic            next_blink;
  logic            run, edit;
  logic            sec_inc, min_inc, hr_inc, sec_clr;
  logic            sec_carry, min_carry, hr_carry_unused;

  assign run  = (state == RUN);
  assign edit = inc_btn && !mode_btn;
  assign mode = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      idle  <= '0;
      blink <= 1'b0;
    end else begin
      state <= next_state;
      idle  <= next_idle;
      blink <= next_blink;
    end
  end

  always_comb begin
    next_state = state;
    next_idle  = idle;
    next_blink = blink;
    case (state)
      RUN:     if (mode_btn) next_state = SET_HR;
      SET_HR:  if (mode_btn) next_state = SET_MIN;
      SET_MIN: if (mode_btn) next_state = RUN;
      default: next_state = RUN;
    endcase
    if (!run && tick) begin
      next_blink = ~blink;
      // A button in the timeout cycle wins: it clears the counter below instead.
      if (!mode_btn && !inc_btn) begin
        if (idle == IDLE_LAST) next_state = RUN;
        else next_idle = idle + 1'b1;
      end
    end
    if (mode_btn || inc_btn || next_state != state) next_idle = '0;
    if (next_state != state) next_blink = 1'b0;
  end

  // Carries only ripple in RUN; edits touch a single field.
  assign sec_inc = run && tick;
  assign min_inc = (run && sec_carry) || (state == SET_MIN && edit);
  assign hr_inc  = (run && min_carry) || (state == SET_HR && edit);
  assign sec_clr = (next_state == RUN) && !run;

  bcd_mod_counter #(.MIN_VAL(8'h00), .RST_VAL(8'h00)) u_sec (
    .clk(clk), .reset(reset), .clr(sec_clr), .inc(sec_inc),
    .max_val(MIN_SEC_MAX), .value(sec_bcd), .carry(sec_carry)
  );

  bcd_mod_counter #(.MIN_VAL(8'h00), .RST_VAL(8'h00)) u_min (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(min_inc),
    .max_val(MIN_SEC_MAX), .value(min_bcd), .carry(min_carry)
  );

  bcd_mod_counter #(.MIN_VAL(HR_MIN), .RST_VAL(HR_RST)) u_hr (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(hr_inc),
    .max_val(hr_limit(TWELVE_HR)), .value(hr_bcd), .carry(hr_carry_unused)
  );

`ifdef CLOCK_CTRL_12H_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pm <= 1'b0;
    else if (hr_inc && hr_bcd == 8'h11) pm <= ~pm;
  end
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// tb/tb_clock_ctrl.sv - self-checking bench for clock_ctrl (table vectors, model scoreboard)
module tb_clock_ctrl;

  localparam int TO = 30;
`ifdef CLOCK_CTRL_12H_EN
  localparam logic [7:0] HR0      = 8'h12;
  localparam logic [7:0] HR_LAST  = 8'h11;
  localparam int         HR_EDITS = 11;
  localparam logic       PM_WRAP  = 1'b1;
`else
  localparam logic [7:0] HR0      = 8'h00;
  localparam logic [7:0] HR_LAST  = 8'h23;
  localparam int         HR_EDITS = 23;
  localparam logic       PM_WRAP  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;
  logic [7:0] hr_bcd, min_bcd, sec_bcd;
  logic [1:0] mode;
  logic blink, pm;

  clock_ctrl #(.AUTO_RUN_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .tick(tick), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .mode(mode),
    .blink(blink), .pm(pm)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic [1:0] md;
    logic       bl;
    logic       pm;
  } out_t;

  typedef struct {
    bit   t;
    bit   m;
    bit   i;
    out_t exp;
  } vec_t;

  out_t sb[$];
  int checks = 0;
  int errors = 0;

  int m_h, m_m, m_s, m_md, m_idle;
  bit m_bl, m_pm;

  function automatic logic [7:0] bcd(int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.hr = bcd(m_h); o.mn = bcd(m_m); o.sc = bcd(m_s);
    o.md = 2'(m_md); o.bl = m_bl; o.pm = m_pm;
    return o;
  endfunction

  function automatic out_t mk_out(logic [7:0] h, logic [7:0] mi, logic [7:0] s,
                                  logic [1:0] md, logic bl, logic p);
    out_t o;
    o.hr = h; o.mn = mi; o.sc = s; o.md = md; o.bl = bl; o.pm = p;
    return o;
  endfunction

  function automatic vec_t mk(bit t, bit m, bit i, out_t e);
    vec_t v;
    v.t = t; v.m = m; v.i = i; v.exp = e;
    return v;
  endfunction

  task automatic model_reset();
`ifdef CLOCK_CTRL_12H_EN
    m_h = 12;
`else
    m_h = 0;
`endif
    m_m = 0; m_s = 0; m_md = 0; m_idle = 0; m_bl = 0; m_pm = 0;
  endtask

  task automatic hr_up();
`ifdef CLOCK_CTRL_12H_EN
    if (m_h == 11) begin m_h = 12; m_pm = ~m_pm; end
    else if (m_h == 12) m_h = 1;
    else m_h = m_h + 1;
`else
    m_h = (m_h + 1) % 24;
`endif
  endtask

  task automatic model_step(bit t, bit m, bit i);
    if (m_md == 0) begin
      if (t) begin
        m_s = m_s + 1;
        if (m_s == 60) begin
          m_s = 0; m_m = m_m + 1;
          if (m_m == 60) begin m_m = 0; hr_up(); end
        end
      end
      if (m) begin m_md = 1; m_bl = 0; m_idle = 0; end
    end else if (m) begin
      m_md = (m_md == 1) ? 2 : 0;
      if (m_md == 0) m_s = 0;
      m_bl = 0; m_idle = 0;
    end else begin
      if (i) begin
        if (m_md == 1) hr_up();
        else m_m = (m_m + 1) % 60;
        m_idle = 0;
      end
      if (t) begin
        if (!i) m_idle = m_idle + 1;
        if (m_idle == TO) begin m_md = 0; m_s = 0; m_bl = 0; m_idle = 0; end
        else m_bl = ~m_bl;
      end
    end
  endtask

  function automatic out_t act();
    return {hr_bcd, min_bcd, sec_bcd, mode, blink, pm};
  endfunction

  task automatic check_out(string name, out_t e);
    out_t a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h:%h:%h mode=%0d blink=%b pm=%b, expected %h:%h:%h mode=%0d blink=%b pm=%b",
               name, a.hr, a.mn, a.sc, a.md, a.bl, a.pm, e.hr, e.mn, e.sc, e.md, e.bl, e.pm);
    end
  endtask

  task automatic check_int(string name, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, a, e);
    end
  endtask

  // Drive one cycle; expectation comes from the table if given, else from the model.
  task automatic drive(bit t, bit m, bit i, bit use_tbl, out_t texp, string name);
    tick = t; mode_btn = m; inc_btn = i;
    model_step(t, m, i);
    if (use_tbl) sb.push_back(texp);
    else sb.push_back(model_out());
    @(posedge clk);
    #1;
    tick = 0; mode_btn = 0; inc_btn = 0;
    check_out(name, sb.pop_front());
  endtask

  task automatic step(bit t, bit m, bit i, string name);
    drive(t, m, i, 1'b0, '0, name);
  endtask

  task automatic do_reset(string name);
    reset = 0; tick = 0; mode_btn = 0; inc_btn = 0;
    #3;
    model_reset();
    check_out(name, mk_out(HR0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    reset = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];
    int toggles;
    logic prev;

    tbl.push_back(mk(0, 1, 0, mk_out(HR0,   8'h00, 8'h37, 2'd1, 1'b0, 1'b0)));
    tbl.push_back(mk(1, 0, 0, mk_out(HR0,   8'h00, 8'h37, 2'd1, 1'b1, 1'b0)));
    tbl.push_back(mk(0, 0, 1, mk_out(8'h01, 8'h00, 8'h37, 2'd1, 1'b1, 1'b0)));
    tbl.push_back(mk(0, 0, 1, mk_out(8'h02, 8'h00, 8'h37, 2'd1, 1'b1, 1'b0)));
    tbl.push_back(mk(0, 0, 1, mk_out(8'h03, 8'h00, 8'h37, 2'd1, 1'b1, 1'b0)));
    tbl.push_back(mk(1, 0, 0, mk_out(8'h03, 8'h00, 8'h37, 2'd1, 1'b0, 1'b0)));
    tbl.push_back(mk(0, 1, 0, mk_out(8'h03, 8'h00, 8'h37, 2'd2, 1'b0, 1'b0)));
    tbl.push_back(mk(0, 0, 1, mk_out(8'h03, 8'h01, 8'h37, 2'd2, 1'b0, 1'b0)));
    tbl.push_back(mk(0, 0, 1, mk_out(8'h03, 8'h02, 8'h37, 2'd2, 1'b0, 1'b0)));
    tbl.push_back(mk(1, 0, 0, mk_out(8'h03, 8'h02, 8'h37, 2'd2, 1'b1, 1'b0)));
    tbl.push_back(mk(0, 1, 0, mk_out(8'h03, 8'h02, 8'h00, 2'd0, 1'b0, 1'b0)));

    #2;
    do_reset("reset_state");

    for (int k = 0; k < 60; k++) step(1, 0, 0, "run_tick");
    check_out("sixty_ticks", mk_out(HR0, 8'h01, 8'h00, 2'd0, 1'b0, 1'b0));

    do_reset("reset_before_edit");
    for (int k = 0; k < 37; k++) step(1, 0, 0, "tick_to_37");
    for (int k = 0; k < tbl.size(); k++) drive(tbl[k].t, tbl[k].m, tbl[k].i, 1'b1, tbl[k].exp, "edit_table");

    step(0, 1, 0, "to_set_hr");
    step(0, 1, 0, "to_set_min");
    for (int k = 0; k < 57; k++) step(0, 0, 1, "min_edit");
    step(0, 1, 1, "mode_beats_inc");
    check_out("mode_inc_same_cycle", mk_out(8'h03, 8'h59, 8'h00, 2'd0, 1'b0, 1'b0));

    for (int k = 0; k < 5; k++) step(1, 0, 0, "pre_idle_tick");
    step(0, 1, 0, "enter_set_hr");
    toggles = 0;
    prev = blink;
    for (int k = 0; k < TO - 1; k++) begin
      step(1, 0, 0, "idle_tick");
      if (blink !== prev) toggles++;
      prev = blink;
    end
    check_int("blink_toggles", toggles, TO - 1);
    step(1, 0, 0, "timeout_tick");
    check_out("timeout_return", mk_out(8'h03, 8'h59, 8'h00, 2'd0, 1'b0, 1'b0));

    do_reset("reset_before_wrap");
    step(0, 1, 0, "wrap_set_hr");
    for (int k = 0; k < HR_EDITS; k++) step(0, 0, 1, "wrap_hr_edit");
    step(0, 1, 0, "wrap_set_min");
    for (int k = 0; k < 59; k++) step(0, 0, 1, "wrap_min_edit");
    step(0, 1, 0, "wrap_run");
    for (int k = 0; k < 59; k++) step(1, 0, 0, "wrap_tick");
    check_out("before_wrap", mk_out(HR_LAST, 8'h59, 8'h59, 2'd0, 1'b0, 1'b0));
    step(1, 0, 0, "wrap_step");
    check_out("day_wrap", mk_out(HR0, 8'h00, 8'h00, 2'd0, 1'b0, PM_WRAP));

    do_reset("reset_before_abort");
    step(0, 1, 0, "abort_set_hr");
    for (int k = 0; k < 5; k++) step(0, 0, 1, "abort_hr_edit");
    step(0, 1, 0, "abort_set_min");
    for (int k = 0; k < 17; k++) step(0, 0, 1, "abort_min_edit");
    check_out("mid_set_min", mk_out(8'h05, 8'h17, 8'h00, 2'd2, 1'b0, 1'b0));
    #5;
    reset = 0;
    #1;
    check_out("reset_mid_set", mk_out(HR0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0));
    model_reset();
    @(posedge clk);
    #1;
    reset = 1;

    for (int k = 0; k < 500; k++) begin
      bit t, m, i;
      t = ($urandom_range(0, 99) < 40);
      m = ($urandom_range(0, 99) < 4);
      i = ($urandom_range(0, 99) < 15);
      step(t, m, i, "random");
    end

    check_int("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
